// File: rtl/ofdm_vlc_pkg.sv
// Shared constants, FSM state type and address helper for the VLC OFDM burst path.
// Build option: TX_IDLE_MIDLEVEL_EN selects the LED DC-bias level (8'h80) for pad and idle samples.
package ofdm_vlc_pkg;

    localparam int FFT_POINT   = 64;
    localparam int CP_NUM      = 16;
    localparam int PRE_SYM_NUM = 4;
    localparam int SYMBOL_NUM  = 8;
    localparam int PAD_NUM     = 160;

    localparam int SYM_TOTAL      = PRE_SYM_NUM + SYMBOL_NUM;
    localparam int BURST_DATA_LEN = SYM_TOTAL * FFT_POINT;
    localparam int BURST_LEN      = SYM_TOTAL * (FFT_POINT + CP_NUM) + PAD_NUM;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int SENT_W = 11;

`ifdef TX_IDLE_MIDLEVEL_EN
    localparam logic [DATA_W-1:0] IDLE_FILL = 8'h80;
`else
    localparam logic [DATA_W-1:0] IDLE_FILL = 8'h00;
`endif

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_CP,
        ST_BODY,
        ST_PAD,
        ST_DONE
    } framer_state_t;

    // Buffer address of sample 0 of symbol k.
    function automatic logic [ADDR_W-1:0] sym_base(input logic [3:0] k);
        return ADDR_W'(int'(k) * FFT_POINT);
    endfunction

endpackage

// File: rtl/ofdm_burst_framer_if.sv
// Sample-in / framed-sample-out bus of the OFDM burst framer.
// Handshake: a write moves when wren && in_ready; an output sample moves when dout_valid && dout_ready,
// and once dout_valid is high, dout and dout_valid hold until that transfer happens.
interface ofdm_burst_framer_if;

    logic [7:0] din;
    logic       wren;
    logic       in_ready;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       tx_done;
    logic       busy;

    modport master (
        output din, wren, dout_ready,
        input  in_ready, dout, dout_valid, tx_done, busy
    );

    modport slave (
        input  din, wren, dout_ready,
        output in_ready, dout, dout_valid, tx_done, busy
    );

endinterface

// File: rtl/tx_sym_buff_srp.sv
// Single-port 1024x8 symbol buffer with one-cycle synchronous read (read-first on write).
module tx_sym_buff_srp (
    input  logic       clk,
    input  logic       we,
    input  logic       en,
    input  logic [9:0] addr,
    input  logic [7:0] di,
    output logic [7:0] dout
);

    logic [7:0] mem [1024];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= di;
            end
            dout <= mem[addr];
        end
    end

endmodule

// File: rtl/ofdm_burst_framer.sv
// Buffers 12 IFFT symbols, then emits CP+body per symbol with a pad gap after the preamble.
// Build option: TX_IDLE_MIDLEVEL_EN (see ofdm_vlc_pkg) sets the pad/idle sample level.
module ofdm_burst_framer
    import ofdm_vlc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    ofdm_burst_framer_if.slave  bus,
    output framer_state_t       dbg_state
);

    framer_state_t       state, state_nxt;
    logic [ADDR_W-1:0]   wr_cnt, wr_nxt;
    logic [3:0]          k, k_nxt;
    logic [7:0]          j, j_nxt;
    logic                busy_q, busy_nxt;
    logic [SENT_W-1:0]   sent;

    logic                in_ready_c;
    logic                wr_acc;
    logic                issue;
    logic                issue_pad;
    logic [ADDR_W-1:0]   rd_addr;
    logic                tx_done_c;

    logic                rd_pend;
    logic                rd_pad;
    logic [DATA_W-1:0]   ram_dout;
    logic [DATA_W-1:0]   land_data;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic                skid_valid;
    logic [DATA_W-1:0]   skid_data;
    logic [1:0]          occ;
    logic                xfer;
    logic                can_issue;

    assign in_ready_c = (state == ST_LOAD) && (wr_cnt < ADDR_W'(BURST_DATA_LEN));
    assign wr_acc     = bus.wren && in_ready_c;
    assign xfer       = out_valid && bus.dout_ready;

    // Output register + skid hold two samples; a read may issue only if its result
    // is guaranteed a slot when it lands, which keeps full rate with dout_ready=1.
    assign occ       = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, rd_pend};
    assign can_issue = (occ - {1'b0, xfer}) < 2'd2;
    assign land_data = rd_pad ? IDLE_FILL : ram_dout;

    tx_sym_buff_srp u_buff (
        .clk  (clk),
        .we   (wr_acc),
        .en   (wr_acc || (issue && !issue_pad)),
        .addr ((state == ST_LOAD) ? wr_cnt : rd_addr),
        .di   (bus.din),
        .dout (ram_dout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_LOAD;
            wr_cnt <= '0;
            k      <= '0;
            j      <= '0;
            busy_q <= 1'b0;
            sent   <= '0;
        end else begin
            state  <= state_nxt;
            wr_cnt <= wr_nxt;
            k      <= k_nxt;
            j      <= j_nxt;
            busy_q <= busy_nxt;
            if (tx_done_c) begin
                sent <= '0;
            end else if (xfer) begin
                sent <= sent + SENT_W'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        wr_nxt    = wr_cnt;
        k_nxt     = k;
        j_nxt     = j;
        busy_nxt  = busy_q;
        issue     = 1'b0;
        issue_pad = 1'b0;
        rd_addr   = '0;
        tx_done_c = 1'b0;
        case (state)
            ST_LOAD: begin
                if (wr_acc) begin
                    wr_nxt   = wr_cnt + ADDR_W'(1);
                    busy_nxt = 1'b1;
                    if (wr_cnt == ADDR_W'(BURST_DATA_LEN - 1)) begin
                        state_nxt = ST_CP;
                        k_nxt     = '0;
                        j_nxt     = '0;
                    end
                end
            end
            ST_CP: begin
                if (can_issue) begin
                    issue   = 1'b1;
                    rd_addr = sym_base(k) + ADDR_W'(FFT_POINT - CP_NUM) + ADDR_W'(j);
                    if (j == 8'(CP_NUM - 1)) begin
                        j_nxt     = '0;
                        state_nxt = ST_BODY;
                    end else begin
                        j_nxt = j + 8'd1;
                    end
                end
            end
            ST_BODY: begin
                if (can_issue) begin
                    issue   = 1'b1;
                    rd_addr = sym_base(k) + ADDR_W'(j);
                    if (j == 8'(FFT_POINT - 1)) begin
                        j_nxt = '0;
                        if (k == 4'(PRE_SYM_NUM - 1)) begin
                            state_nxt = ST_PAD;
                        end else if (k == 4'(SYM_TOTAL - 1)) begin
                            state_nxt = ST_DONE;
                        end else begin
                            k_nxt     = k + 4'd1;
                            state_nxt = ST_CP;
                        end
                    end else begin
                        j_nxt = j + 8'd1;
                    end
                end
            end
            ST_PAD: begin
                if (can_issue) begin
                    issue     = 1'b1;
                    issue_pad = 1'b1;
                    if (j == 8'(PAD_NUM - 1)) begin
                        j_nxt     = '0;
                        k_nxt     = 4'(PRE_SYM_NUM);
                        state_nxt = ST_CP;
                    end else begin
                        j_nxt = j + 8'd1;
                    end
                end
            end
            ST_DONE: begin
                // Wait here until the pipeline has handed over the final sample.
                if (sent == SENT_W'(BURST_LEN)) begin
                    tx_done_c = 1'b1;
                    busy_nxt  = 1'b0;
                    wr_nxt    = '0;
                    k_nxt     = '0;
                    j_nxt     = '0;
                    state_nxt = ST_LOAD;
                end
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend    <= 1'b0;
            rd_pad     <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= IDLE_FILL;
            skid_valid <= 1'b0;
            skid_data  <= IDLE_FILL;
        end else begin
            rd_pend <= issue;
            rd_pad  <= issue_pad;
            if (!out_valid || xfer) begin
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_data   <= skid_data;
                    skid_valid <= rd_pend;
                    skid_data  <= land_data;
                end else if (rd_pend) begin
                    out_valid <= 1'b1;
                    out_data  <= land_data;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (rd_pend) begin
                skid_valid <= 1'b1;
                skid_data  <= land_data;
            end
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.dout       = out_valid ? out_data : IDLE_FILL;
    assign bus.dout_valid = out_valid;
    assign bus.tx_done    = tx_done_c;
    assign bus.busy       = busy_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_ofdm_burst_framer.sv
// Self-checking bench for ofdm_burst_framer: directed bursts, checkpoint table, backpressure, reset abort.
// Build option: TX_IDLE_MIDLEVEL_EN changes the expected pad/idle level.
module tb_ofdm_burst_framer;
    import ofdm_vlc_pkg::*;

`ifdef TX_IDLE_MIDLEVEL_EN
    localparam logic [7:0] FILL = 8'h80;
`else
    localparam logic [7:0] FILL = 8'h00;
`endif

    typedef struct {
        int         idx;
        logic [7:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    framer_state_t dbg_state;

    ofdm_burst_framer_if bus();

    ofdm_burst_framer dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] cap [BURST_LEN];
    int         n_xfer, n_done, done_at, stab_err, ir_err;
    logic       bp_mode, prev_hold;
    logic [7:0] prev_dout;
    logic       s_valid, s_in_ready, s_tx_done, s_busy;
    logic [7:0] s_dout;
    framer_state_t s_state;
    vec_t       vecs [10];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock: sample/monitor at negedge, then drive after the rising edge.
    task automatic tick();
        @(negedge clk);
        s_valid    = bus.dout_valid;
        s_in_ready = bus.in_ready;
        s_tx_done  = bus.tx_done;
        s_busy     = bus.busy;
        s_dout     = bus.dout;
        s_state    = dbg_state;
        if (!rst) begin
            if (prev_hold && (!bus.dout_valid || bus.dout != prev_dout)) stab_err++;
            prev_hold = bus.dout_valid && !bus.dout_ready;
            prev_dout = bus.dout;
            if (bus.dout_valid && bus.dout_ready) begin
                if (n_xfer < BURST_LEN) cap[n_xfer] = bus.dout;
                n_xfer++;
            end
            if (bus.tx_done) begin
                n_done++;
                done_at = n_xfer;
            end
            if (bus.dout_valid && bus.in_ready) ir_err++;
        end else begin
            prev_hold = 1'b0;
        end
        @(posedge clk);
        #1;
        bus.dout_ready = bp_mode ? 1'($urandom_range(1, 0)) : 1'b1;
    endtask

    function automatic logic [7:0] pat(input int sel, input int n);
        if (sel == 0) return 8'(n % 256);
        return 8'((n * 7 + 3) % 256);
    endfunction

    // Reference burst: 4 x (16 CP + 64 body), 160 pad, 8 x (16 CP + 64 body).
    function automatic logic [7:0] exp_sample(input int sel, input int i);
        int sym, o;
        if (i < 320) begin
            sym = i / 80;
            o   = i % 80;
        end else if (i < 480) begin
            return FILL;
        end else begin
            sym = 4 + (i - 480) / 80;
            o   = (i - 480) % 80;
        end
        if (o < 16) return pat(sel, sym * 64 + 48 + o);
        return pat(sel, sym * 64 + o - 16);
    endfunction

    task automatic start_burst();
        n_xfer    = 0;
        n_done    = 0;
        done_at   = -1;
        stab_err  = 0;
        ir_err    = 0;
        prev_hold = 1'b0;
    endtask

    task automatic load_burst(input int sel, input logic hold);
        for (int n = 0; n < BURST_DATA_LEN; n++) begin
            bus.din  = pat(sel, n);
            bus.wren = 1'b1;
            tick();
        end
        bus.wren = hold;
        bus.din  = hold ? 8'hAA : 8'h00;
    endtask

    task automatic wait_done(input string name);
        int budget = 0;
        while (n_done == 0 && budget < 6000) begin
            tick();
            budget++;
        end
        check({name, "_done_seen"}, int'(n_done > 0), 1);
    endtask

    task automatic check_seq(input string name, input int sel);
        int bad   = 0;
        int first = -1;
        logic [7:0] e;
        exp_q.delete();
        for (int i = 0; i < BURST_LEN; i++) exp_q.push_back(exp_sample(sel, i));
        for (int i = 0; i < BURST_LEN; i++) begin
            e = exp_q.pop_front();
            if (cap[i] != e) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        check({name, "_count"}, n_xfer, BURST_LEN);
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s_seq: %0d samples differ, first at #%0d got %0d expected %0d",
                     name, bad, first, cap[first], exp_sample(sel, first));
        end
        check({name, "_tx_done_pulses"}, n_done, 1);
        check({name, "_tx_done_after_last"}, done_at, BURST_LEN);
    endtask

    initial begin
        int padbad;
        int budget;

        vecs[0] = '{0,    8'd48};
        vecs[1] = '{15,   8'd63};
        vecs[2] = '{16,   8'd0};
        vecs[3] = '{79,   8'd63};
        vecs[4] = '{80,   8'd112};
        vecs[5] = '{320,  FILL};
        vecs[6] = '{400,  FILL};
        vecs[7] = '{479,  FILL};
        vecs[8] = '{480,  8'd48};
        vecs[9] = '{1119, 8'd255};

        rst            = 1'b1;
        bus.din        = 8'h00;
        bus.wren       = 1'b0;
        bus.dout_ready = 1'b1;
        bp_mode        = 1'b0;
        prev_hold      = 1'b0;
        prev_dout      = 8'h00;
        start_burst();
        repeat (3) tick();

        check("rst_dout", int'(s_dout), int'(FILL));
        check("rst_dout_valid", int'(s_valid), 0);
        check("rst_in_ready", int'(s_in_ready), 1);
        check("rst_tx_done", int'(s_tx_done), 0);
        check("rst_busy", int'(s_busy), 0);
        check("rst_state", int'(s_state), int'(ST_LOAD));
        rst = 1'b0;
        tick();

        // Burst 1: ramp data, no backpressure, latency and checkpoint table.
        start_burst();
        load_burst(0, 1'b0);
        check("b1_busy_loading", int'(s_busy), 1);
        tick();
        check("b1_lat1_valid", int'(s_valid), 0);
        check("b1_lat1_in_ready", int'(s_in_ready), 0);
        tick();
        check("b1_lat2_valid", int'(s_valid), 0);
        tick();
        check("b1_lat3_valid", int'(s_valid), 1);
        check("b1_first_dout", int'(s_dout), 48);
        wait_done("b1");
        check_seq("b1", 0);
        for (int v = 0; v < 10; v++) begin
            check($sformatf("b1_sample_%0d", vecs[v].idx), int'(cap[vecs[v].idx]), int'(vecs[v].exp));
        end
        padbad = 0;
        for (int i = 320; i < 480; i++) if (cap[i] != FILL) padbad++;
        check("b1_pad_run_bad", padbad, 0);
        tick();
        check("b1_busy_after", int'(s_busy), 0);
        check("b1_in_ready_after", int'(s_in_ready), 1);

        // Burst 2: random backpressure.
        bp_mode = 1'b1;
        start_burst();
        load_burst(0, 1'b0);
        wait_done("b2");
        check_seq("b2", 0);
        check("b2_hold_stable", stab_err, 0);
        bp_mode = 1'b0;
        tick();

        // Burst 3: new data, wren held high through the whole emission.
        start_burst();
        load_burst(1, 1'b1);
        wait_done("b3");
        check_seq("b3", 1);
        check("b3_in_ready_low_emit", ir_err, 0);

        // Burst 4: reload starts at address 0 right after tx_done.
        start_burst();
        load_burst(0, 1'b0);
        wait_done("b4");
        check_seq("b4", 0);

        // Burst 5: reset mid-burst, then a clean reload.
        start_burst();
        load_burst(0, 1'b0);
        budget = 0;
        while (n_xfer < 500 && budget < 3000) begin
            tick();
            budget++;
        end
        check("b5_reached_500", int'(n_xfer >= 500), 1);
        rst = 1'b1;
        tick();
        check("b5_rst_dout_valid", int'(s_valid), 0);
        check("b5_rst_busy", int'(s_busy), 0);
        check("b5_rst_in_ready", int'(s_in_ready), 1);
        check("b5_rst_tx_done", int'(s_tx_done), 0);
        check("b5_rst_dout", int'(s_dout), int'(FILL));
        rst = 1'b0;
        tick();
        start_burst();
        load_burst(0, 1'b0);
        wait_done("b5");
        check_seq("b5", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
